// File: rtl/dm_port_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter: DM access modes, arbiter
// states and the port-owner select.
package dm_port_arbiter_pkg;

    localparam logic [3:0] DM_WORD           = 4'd0;
    localparam logic [3:0] DM_HALF           = 4'd1;
    localparam logic [3:0] DM_BYTE           = 4'd2;
    localparam logic [3:0] DM_HALF_UNSIGNED  = 4'd3;
    localparam logic [3:0] DM_BYTE_UNSIGNED  = 4'd4;

    typedef enum logic {
        S_CPU = 1'b0,
        S_DMA = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dm_port_arbiter.sv
// Arbitrates the single DM/bridge port between the CPU MEM stage (priority owner)
// and a word-wide DMA requester with starvation forcing and capped burst tenure.
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_mode,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic        dma_last,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        mem_we,
    output logic [3:0]  mem_mode,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] STARVE_C = 8'(STARVE_MAX);
    localparam logic [7:0] BURST_C  = 8'(MAX_BURST);
    localparam logic       MULTI_BEAT = (MAX_BURST > 1);

    arb_state_e state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [7:0] beat_q, beat_d;
    owner_e     owner;
    logic       force_dma;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_CPU;
            wait_q  <= 8'd0;
            beat_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
        end
    end

    assign force_dma = (wait_q == STARVE_C);

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        beat_d    = beat_q;
        owner     = OWN_NONE;
        dma_gnt   = 1'b0;
        cpu_stall = 1'b0;
        case (state_q)
            S_CPU: begin
                // A forced grant only preempts the CPU when DMA is actually asking.
                if (cpu_req && !(force_dma && dma_req)) begin
                    owner  = OWN_CPU;
                    wait_d = dma_req ? sat_inc8(wait_q) : 8'd0;
                end else if (dma_req) begin
                    owner     = OWN_DMA;
                    dma_gnt   = 1'b1;
                    cpu_stall = cpu_req;
                    wait_d    = 8'd0;
                    beat_d    = 8'd1;
                    if (!dma_last && MULTI_BEAT) begin
                        state_d = S_DMA;
                    end
                end else begin
                    wait_d = 8'd0;
                end
            end
            S_DMA: begin
                cpu_stall = cpu_req;
                if (dma_req) begin
                    owner   = OWN_DMA;
                    dma_gnt = 1'b1;
                    beat_d  = beat_q + 8'd1;
                    if (dma_last || (beat_d >= BURST_C)) begin
                        state_d = S_CPU;
                    end
                end
            end
            default: state_d = S_CPU;
        endcase
        // Reset abandons any burst and keeps the port quiet for this cycle.
        if (reset) begin
            owner     = OWN_NONE;
            dma_gnt   = 1'b0;
            cpu_stall = 1'b0;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_mode  = DM_WORD;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        case (owner)
            OWN_CPU: begin
                mem_we    = cpu_we;
                mem_mode  = cpu_mode;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            OWN_DMA: begin
                mem_we    = dma_we;
                mem_mode  = DM_WORD;
                mem_addr  = {dma_addr[31:2], 2'b00};
                mem_wdata = dma_wdata;
            end
            default: ;
        endcase
    end

    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: each cycle's expected port outputs are queued
// when the inputs are driven and checked at the following negedge.
module tb_dm_port_arbiter;
    import dm_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [3:0]  cpu_mode;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dma_req, dma_we, dma_last;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_gnt;
    logic        mem_we;
    logic [3:0]  mem_mode;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int tests_run = 0;
    int n_fail    = 0;

    typedef struct {
        string       tag;
        logic        we;
        logic [3:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        stall;
        logic        gnt;
        logic [31:0] rdata;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    dm_port_arbiter #(.STARVE_MAX(8), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_mode(cpu_mode),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_last(dma_last),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
        .dma_rdata(dma_rdata),
        .mem_we(mem_we), .mem_mode(mem_mode), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [3:0] mode,
                           input logic [31:0] addr, input logic [31:0] wd);
        cpu_req = req; cpu_we = we; cpu_mode = mode; cpu_addr = addr; cpu_wdata = wd;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic last,
                           input logic [31:0] addr, input logic [31:0] wd);
        dma_req = req; dma_we = we; dma_last = last; dma_addr = addr; dma_wdata = wd;
    endtask

    task automatic step(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] mode,
                        input logic stall, input logic gnt);
        exp_t e;
        mem_rdata = $urandom;
        e.tag = tag; e.we = we; e.mode = mode; e.addr = addr; e.wdata = wd;
        e.stall = stall; e.gnt = gnt; e.rdata = mem_rdata;
        sbq.push_back(e);
        @(negedge clk);
        e = sbq.pop_front();
        chk({e.tag, ".we"},    32'(mem_we),    32'(e.we));
        chk({e.tag, ".mode"},  32'(mem_mode),  32'(e.mode));
        chk({e.tag, ".addr"},  mem_addr,       e.addr);
        chk({e.tag, ".wdata"}, mem_wdata,      e.wdata);
        chk({e.tag, ".stall"}, 32'(cpu_stall), 32'(e.stall));
        chk({e.tag, ".gnt"},   32'(dma_gnt),   32'(e.gnt));
        chk({e.tag, ".crd"},   cpu_rdata,      e.rdata);
        chk({e.tag, ".drd"},   dma_rdata,      e.rdata);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        mem_rdata = 32'd0;
        set_cpu(1'b0, 1'b0, DM_WORD, 32'd0, 32'd0);
        set_dma(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1;

        // Reset: both requesting, port must stay quiet.
        set_cpu(1'b1, 1'b1, DM_WORD, 32'h10, 32'h1111_1111);
        set_dma(1'b1, 1'b1, 1'b1, 32'h100, 32'h2222_2222);
        step("reset", 1'b0, 32'd0, 32'd0, DM_WORD, 1'b0, 1'b0);
        reset = 1'b0;

        // CPU only.
        set_dma(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_cpu(1'b1, 1'b1, DM_WORD, 32'h10, 32'h1234_5678);
        step("cpu_sw", 1'b1, 32'h10, 32'h1234_5678, DM_WORD, 1'b0, 1'b0);
        set_cpu(1'b1, 1'b0, DM_HALF, 32'h22, 32'h0);
        step("cpu_lh", 1'b0, 32'h22, 32'h0, DM_HALF, 1'b0, 1'b0);
        set_cpu(1'b0, 1'b0, DM_BYTE, 32'h33, 32'h55);
        step("idle", 1'b0, 32'd0, 32'd0, DM_WORD, 1'b0, 1'b0);

        // DMA only, 3-beat burst; low address bits and cpu_mode ignored.
        set_dma(1'b1, 1'b1, 1'b0, 32'h201, 32'hA0A0_0000);
        step("dma_b1", 1'b1, 32'h200, 32'hA0A0_0000, DM_WORD, 1'b0, 1'b1);
        set_dma(1'b1, 1'b1, 1'b0, 32'h206, 32'hA0A0_0001);
        step("dma_b2", 1'b1, 32'h204, 32'hA0A0_0001, DM_WORD, 1'b0, 1'b1);
        set_dma(1'b1, 1'b1, 1'b1, 32'h208, 32'hA0A0_0002);
        step("dma_b3", 1'b1, 32'h208, 32'hA0A0_0002, DM_WORD, 1'b0, 1'b1);
        // Back in S_CPU: CPU gets the port at once (S_DMA would stall it).
        set_dma(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_cpu(1'b1, 1'b1, DM_BYTE, 32'h13, 32'h0000_00EE);
        step("dma_done_cpu", 1'b1, 32'h13, 32'h0000_00EE, DM_BYTE, 1'b0, 1'b0);

        // Starvation: 8 CPU cycles, then a forced DMA beat.
        set_cpu(1'b1, 1'b1, DM_WORD, 32'h30, 32'h11);
        set_dma(1'b1, 1'b1, 1'b1, 32'h300, 32'h22);
        for (int i = 0; i < 8; i++)
            step($sformatf("starve_cpu%0d", i), 1'b1, 32'h30, 32'h11, DM_WORD, 1'b0, 1'b0);
        step("starve_force", 1'b1, 32'h300, 32'h22, DM_WORD, 1'b1, 1'b1);
        step("starve_after", 1'b1, 32'h30, 32'h11, DM_WORD, 1'b0, 1'b0);
        set_cpu(1'b0, 1'b0, DM_WORD, 32'd0, 32'd0);
        set_dma(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step("starve_idle", 1'b0, 32'd0, 32'd0, DM_WORD, 1'b0, 1'b0);

        // Burst cap of 4 on a 6-beat burst, CPU waiting from beat 2.
        set_dma(1'b1, 1'b1, 1'b0, 32'h400, 32'hB0);
        step("cap_b1", 1'b1, 32'h400, 32'hB0, DM_WORD, 1'b0, 1'b1);
        set_cpu(1'b1, 1'b1, DM_WORD, 32'h40, 32'hC0);
        for (int i = 2; i <= 4; i++) begin
            set_dma(1'b1, 1'b1, 1'b0, 32'h400 + 32'(4 * (i - 1)), 32'hB0 + 32'(i - 1));
            step($sformatf("cap_b%0d", i), 1'b1, 32'h400 + 32'(4 * (i - 1)),
                 32'hB0 + 32'(i - 1), DM_WORD, 1'b1, 1'b1);
        end
        set_dma(1'b1, 1'b1, 1'b0, 32'h410, 32'hB4);
        step("cap_cpu", 1'b1, 32'h40, 32'hC0, DM_WORD, 1'b0, 1'b0);
        set_cpu(1'b0, 1'b0, DM_WORD, 32'd0, 32'd0);
        step("cap_b5", 1'b1, 32'h410, 32'hB4, DM_WORD, 1'b0, 1'b1);
        set_dma(1'b1, 1'b0, 1'b1, 32'h414, 32'hB5);
        step("cap_b6", 1'b0, 32'h414, 32'hB5, DM_WORD, 1'b0, 1'b1);
        set_dma(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step("cap_idle", 1'b0, 32'd0, 32'd0, DM_WORD, 1'b0, 1'b0);

        // Reset at beat 2 abandons the burst.
        set_dma(1'b1, 1'b1, 1'b0, 32'h500, 32'hD0);
        step("rst_b1", 1'b1, 32'h500, 32'hD0, DM_WORD, 1'b0, 1'b1);
        reset = 1'b1;
        set_cpu(1'b1, 1'b1, DM_WORD, 32'h50, 32'hE0);
        set_dma(1'b1, 1'b1, 1'b0, 32'h504, 32'hD1);
        step("rst_b2", 1'b0, 32'd0, 32'd0, DM_WORD, 1'b0, 1'b0);
        reset = 1'b0;
        step("rst_cpu", 1'b1, 32'h50, 32'hE0, DM_WORD, 1'b0, 1'b0);
        set_cpu(1'b0, 1'b0, DM_WORD, 32'd0, 32'd0);
        set_dma(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step("rst_idle", 1'b0, 32'd0, 32'd0, DM_WORD, 1'b0, 1'b0);

        // dma_req drops for 2 cycles mid-burst; tenure is held.
        set_dma(1'b1, 1'b1, 1'b0, 32'h600, 32'hF0);
        step("gap_b1", 1'b1, 32'h600, 32'hF0, DM_WORD, 1'b0, 1'b1);
        set_dma(1'b0, 1'b1, 1'b0, 32'h604, 32'hF1);
        set_cpu(1'b1, 1'b1, DM_WORD, 32'h60, 32'h99);
        step("gap_bub1", 1'b0, 32'd0, 32'd0, DM_WORD, 1'b1, 1'b0);
        step("gap_bub2", 1'b0, 32'd0, 32'd0, DM_WORD, 1'b1, 1'b0);
        set_dma(1'b1, 1'b1, 1'b1, 32'h604, 32'hF1);
        step("gap_b2", 1'b1, 32'h604, 32'hF1, DM_WORD, 1'b1, 1'b1);
        set_dma(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step("gap_cpu", 1'b1, 32'h60, 32'h99, DM_WORD, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, n_fail);
        $finish;
    end

endmodule
